// File: rtl/disk_uart_ctrl.sv
// disk_uart_ctrl: memory-mapped sector buffer that moves whole sectors over an 8N1 UART link.
// Optional macro DISK_CHECKSUM_EN appends an XOR checksum byte to data in both directions.
module disk_uart_ctrl #(
  parameter int ADDR_W       = 9,
  parameter int SECTOR_WORDS = 128,
  parameter int CLK_DIV      = 434,
  parameter int TIMEOUT_CYC  = 2_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Memread,
  input  logic              Memwrite,
  input  logic [ADDR_W-1:0] Addrin,
  input  logic [31:0]       bus_wdata,
  output logic [31:0]       bus_rdata,
  input  logic              RxD,
  output logic              TxD,
  output logic              irq
);
`ifdef DISK_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif
  localparam int WIDX   = $clog2(SECTOR_WORDS);
  localparam int NBYTES = SECTOR_WORDS * 4;
  localparam int BW     = $clog2(NBYTES) + 1;
  localparam int DW     = $clog2(CLK_DIV);
  localparam int TW     = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [3:0] {
    IDLE, TX_HDR, TX_DATA, TX_CSUM, TX_WAIT, RX_DATA, RX_CSUM, RX_ACK, FIN, FAIL
  } state_t;

  state_t            state;
  logic              busy, error, done, cmd_rd;
  logic [31:0]       lba, status, tx_word;
  logic [BW-1:0]     bcnt;
  logic [TW-1:0]     to_cnt;
  logic [7:0]        csum, tx_byte, tx_hold;
  logic [23:0]       wsh;
  logic [31:0]       buf_mem [SECTOR_WORDS];
  logic              reg_sel, cmd_wr, cpu_buf_wr, rx_wr;
  logic [ADDR_W-2:0] reg_off;
  logic [WIDX-1:0]   cpu_idx;

  logic              rxd_p0, rxd_p1, rxd_p2, rx_act, rx_vld, rx_err;
  logic [DW-1:0]     rx_div, tx_div;
  logic [3:0]        rx_bit, tx_bit;
  logic [7:0]        rx_sh;
  logic              tx_act, tx_hold_vld, tx_load, tx_take;
  logic [8:0]        tx_sh;

  function automatic logic [7:0] hdr_byte(input logic [2:0] i, input logic rd,
                                          input logic [31:0] a);
    case (i)
      3'd0:    hdr_byte = rd ? 8'h52 : 8'h57;
      3'd1:    hdr_byte = a[7:0];
      3'd2:    hdr_byte = a[15:8];
      3'd3:    hdr_byte = a[23:16];
      default: hdr_byte = a[31:24];
    endcase
  endfunction

  assign reg_sel    = Addrin[ADDR_W-1];
  assign reg_off    = Addrin[ADDR_W-2:0];
  assign cpu_idx    = Addrin[WIDX-1:0];
  assign cmd_wr     = Memwrite && reg_sel && (reg_off == (ADDR_W-1)'(2)) &&
                      ((bus_wdata == 32'd1) || (bus_wdata == 32'd2));
  assign cpu_buf_wr = Memwrite && !reg_sel && !busy;
  assign rx_wr      = (state == RX_DATA) && rx_vld && (bcnt[1:0] == 2'd3);
  assign status     = {28'd0, CSUM_EN, done, error, busy};
  assign tx_word    = buf_mem[bcnt[BW-2:2]];
  // The next byte is taken exactly as the stop bit ends, so frames run back-to-back.
  assign tx_take    = tx_hold_vld &&
                      (!tx_act || ((tx_div == DW'(CLK_DIV-1)) && (tx_bit == 4'd9)));

  always_comb begin
    tx_load = 1'b0;
    tx_byte = 8'h00;
    case (state)
      TX_HDR:  begin tx_load = !tx_hold_vld; tx_byte = hdr_byte(bcnt[2:0], cmd_rd, lba); end
      TX_DATA: begin tx_load = !tx_hold_vld; tx_byte = tx_word[{bcnt[1:0], 3'b000} +: 8]; end
      TX_CSUM: begin tx_load = !tx_hold_vld; tx_byte = csum; end
      default: ;
    endcase
  end

  // rx stage: double-flop sync (p0/p1), p2 holds the previous level for edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_p0 <= 1'b1; rxd_p1 <= 1'b1; rxd_p2 <= 1'b1;
      rx_act <= 1'b0; rx_vld <= 1'b0; rx_err <= 1'b0;
      rx_div <= '0;   rx_bit <= '0;
    end else begin
      rxd_p0 <= RxD; rxd_p1 <= rxd_p0; rxd_p2 <= rxd_p1;
      rx_vld <= 1'b0;
      rx_err <= 1'b0;
      if (!rx_act) begin
        if (rxd_p2 && !rxd_p1) begin
          rx_act <= 1'b1;
          rx_div <= DW'(CLK_DIV/2 - 1);
          rx_bit <= '0;
        end
      end else if (rx_div != '0) begin
        rx_div <= rx_div - 1'b1;
      end else begin
        rx_div <= DW'(CLK_DIV-1);
        rx_bit <= rx_bit + 1'b1;
        if (rx_bit == 4'd0) begin
          if (rxd_p1) rx_act <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_act <= 1'b0;
          rx_vld <= rxd_p1;
          rx_err <= !rxd_p1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_act && (rx_div == '0) && (rx_bit != 4'd0) && (rx_bit != 4'd9))
      rx_sh <= {rxd_p1, rx_sh[7:1]};
  end

  // tx stage: one-byte holding register feeding the bit shifter
  always_ff @(posedge clk) begin
    if (rst) begin
      TxD <= 1'b1; tx_act <= 1'b0; tx_hold_vld <= 1'b0;
      tx_div <= '0; tx_bit <= '0;
    end else begin
      if (tx_load)      tx_hold_vld <= 1'b1;
      else if (tx_take) tx_hold_vld <= 1'b0;
      if (tx_take) begin
        TxD <= 1'b0; tx_act <= 1'b1; tx_div <= '0; tx_bit <= '0;
      end else if (tx_act) begin
        if (tx_div == DW'(CLK_DIV-1)) begin
          tx_div <= '0;
          if (tx_bit == 4'd9) begin
            tx_act <= 1'b0; TxD <= 1'b1;
          end else begin
            tx_bit <= tx_bit + 1'b1; TxD <= tx_sh[0];
          end
        end else begin
          tx_div <= tx_div + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_load) tx_hold <= tx_byte;
    if (tx_take) tx_sh <= {1'b1, tx_hold};
    else if (tx_act && (tx_div == DW'(CLK_DIV-1)) && (tx_bit != 4'd9))
      tx_sh <= {1'b1, tx_sh[8:1]};
  end

  // command stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE; busy <= 1'b0; error <= 1'b0; done <= 1'b0; irq <= 1'b0;
      lba <= '0; cmd_rd <= 1'b0; bcnt <= '0; to_cnt <= '0;
    end else begin
      irq <= 1'b0;
      if (Memwrite && reg_sel && (reg_off == (ADDR_W-1)'(1))) lba <= bus_wdata;
      case (state)
        IDLE: if (cmd_wr) begin
          cmd_rd <= (bus_wdata == 32'd1);
          busy <= 1'b1; done <= 1'b0; error <= 1'b0;
          bcnt <= '0; csum <= 8'h00;
          state <= TX_HDR;
        end
        TX_HDR: if (tx_load) begin
          if (bcnt == BW'(4)) begin
            bcnt  <= '0;
            state <= cmd_rd ? TX_WAIT : TX_DATA;
          end else bcnt <= bcnt + 1'b1;
        end
        TX_DATA: if (tx_load) begin
          csum <= csum ^ tx_byte;
          if (bcnt == BW'(NBYTES-1)) begin
            bcnt  <= '0;
            state <= CSUM_EN ? TX_CSUM : TX_WAIT;
          end else bcnt <= bcnt + 1'b1;
        end
        TX_CSUM: if (tx_load) state <= TX_WAIT;
        TX_WAIT: if (!tx_act && !tx_hold_vld) begin
          to_cnt <= '0; csum <= 8'h00;
          state  <= cmd_rd ? RX_DATA : RX_ACK;
        end
        RX_DATA, RX_CSUM, RX_ACK: begin
          if (rx_err || (!rx_vld && (to_cnt == TW'(TIMEOUT_CYC-1)))) begin
            state <= FAIL;
          end else if (rx_vld) begin
            to_cnt <= '0;
            if (state == RX_DATA) begin
              csum <= csum ^ rx_sh;
              wsh  <= {rx_sh, wsh[23:8]};
              bcnt <= bcnt + 1'b1;
              if (bcnt == BW'(NBYTES-1)) state <= CSUM_EN ? RX_CSUM : FIN;
            end else if (state == RX_CSUM) begin
              state <= (rx_sh == csum) ? FIN : FAIL;
            end else begin
              state <= (rx_sh == 8'h06) ? FIN : FAIL;
            end
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        FIN:  begin busy <= 1'b0; done  <= 1'b1; irq <= 1'b1; state <= IDLE; end
        FAIL: begin busy <= 1'b0; error <= 1'b1; irq <= 1'b1; state <= IDLE; end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (cpu_buf_wr) buf_mem[cpu_idx] <= bus_wdata;
    else if (rx_wr) buf_mem[bcnt[BW-2:2]] <= {rx_sh, wsh};
  end

  always_ff @(posedge clk) begin
    if (rst) bus_rdata <= '0;
    else if (Memread) begin
      if (!reg_sel)                            bus_rdata <= buf_mem[cpu_idx];
      else if (reg_off == (ADDR_W-1)'(0))      bus_rdata <= status;
      else if (reg_off == (ADDR_W-1)'(1))      bus_rdata <= lba;
      else                                     bus_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_disk_uart_ctrl.sv
// Bench for disk_uart_ctrl: register/buffer vector table, then UART command sequences
// with a host-side UART driver and a TxD byte monitor.
module tb_disk_uart_ctrl;
  localparam int ADDR_W = 9, SW = 4, CLK_DIV = 8, TMO = 200;
`ifdef DISK_CHECKSUM_EN
  localparam logic [31:0] CS = 32'h8;
  localparam int NCS = 1;
`else
  localparam logic [31:0] CS = 32'h0;
  localparam int NCS = 0;
`endif
  localparam logic [8:0] A_STAT = 9'h100, A_LBA = 9'h101, A_CMD = 9'h102;
  localparam int NW = 5 + SW*4 + NCS;

  typedef struct {
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0, rst = 1'b1, Memread = 1'b0, Memwrite = 1'b0, RxD = 1'b1;
  logic [ADDR_W-1:0] Addrin = '0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic TxD, irq;

  int n_checks = 0, n_fail = 0, irq_cnt = 0, tx_frm = 0;
  logic [7:0] tx_q[$];
  logic [7:0] mon_b;

  disk_uart_ctrl #(.ADDR_W(ADDR_W), .SECTOR_WORDS(SW), .CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .Memread(Memread), .Memwrite(Memwrite), .Addrin(Addrin),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .RxD(RxD), .TxD(TxD), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (irq === 1'b1) irq_cnt <= irq_cnt + 1;

  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (TxD === 1'b0) begin
        repeat (CLK_DIV/2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CLK_DIV) @(negedge clk);
          mon_b[i] = TxD;
        end
        repeat (CLK_DIV) @(negedge clk);
        if (TxD !== 1'b1) tx_frm++;
        tx_q.push_back(mon_b);
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [8:0] a, input logic [31:0] d);
    @(negedge clk); Addrin = a; bus_wdata = d; Memwrite = 1'b1;
    @(negedge clk); Memwrite = 1'b0;
  endtask

  task automatic bus_rd(input logic [8:0] a, output logic [31:0] d);
    @(negedge clk); Addrin = a; Memread = 1'b1;
    @(negedge clk); Memread = 1'b0; d = bus_rdata;
  endtask

  task automatic host_send(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RxD = frame[i];
      repeat (CLK_DIV) @(negedge clk);
    end
    RxD = 1'b1;
  endtask

  task automatic wait_txq(input int n, input string name);
    int t;
    t = 0;
    while (tx_q.size() < n && t < 4000) begin @(negedge clk); t++; end
    if (tx_q.size() < n) begin
      n_checks++; n_fail++;
      $display("FAIL %s: %0d bytes on TxD, expected %0d", name, tx_q.size(), n);
    end
  endtask

  task automatic wait_idle(input string name);
    logic [31:0] s;
    int t;
    t = 0;
    do begin bus_rd(A_STAT, s); t++; end while (s[0] !== 1'b0 && t < 600);
    if (s[0] !== 1'b0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: still busy after %0d polls, expected idle", name, t);
    end
  endtask

  task automatic check_tx(input string name, input logic [7:0] exp[$]);
    check({name, " count"}, 32'(tx_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s byte%0d", name, i),
            (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
  endtask

  initial begin : main
    vec_t tbl[13];
    logic [31:0] r;
    logic [7:0] exp[$];
    int irq0;

    tbl[0]  = '{1'b0, A_STAT, 32'h0,         CS};
    tbl[1]  = '{1'b0, A_LBA,  32'h0,         32'h0};
    tbl[2]  = '{1'b1, A_LBA,  32'h1234_5678, 32'h0};
    tbl[3]  = '{1'b0, A_LBA,  32'h0,         32'h1234_5678};
    tbl[4]  = '{1'b0, 9'h103, 32'h0,         32'h0};
    tbl[5]  = '{1'b0, 9'h1FF, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, 9'h001, 32'hA5A5_0001, 32'h0};
    tbl[7]  = '{1'b0, 9'h001, 32'h0,         32'hA5A5_0001};
    tbl[8]  = '{1'b0, 9'h005, 32'h0,         32'hA5A5_0001};
    tbl[9]  = '{1'b1, 9'h0FE, 32'h1111_2222, 32'h0};
    tbl[10] = '{1'b0, 9'h002, 32'h0,         32'h1111_2222};
    tbl[11] = '{1'b1, A_CMD,  32'h3,         32'h0};
    tbl[12] = '{1'b0, A_STAT, 32'h0,         CS};

    repeat (3) @(negedge clk);
    check("reset bus_rdata", bus_rdata, 32'h0);
    check("reset TxD", {31'h0, TxD}, 32'h1);
    check("reset irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) bus_wr(tbl[i].addr, tbl[i].data);
      else begin
        bus_rd(tbl[i].addr, r);
        check($sformatf("vec%0d addr %h", i, tbl[i].addr), r, tbl[i].exp);
      end
    end
    check("invalid cmd no tx", 32'(tx_q.size()), 32'h0);

    // Read sector
    irq0 = irq_cnt;
    bus_wr(A_LBA, 32'h5);
    tx_q.delete();
    bus_wr(A_CMD, 32'h1);
    bus_rd(A_STAT, r);
    check("read busy", r, 32'h1 | CS);
    wait_txq(5, "read hdr");
    exp = '{8'h52, 8'h05, 8'h00, 8'h00, 8'h00};
    check_tx("read hdr", exp);
    repeat (2*CLK_DIV) @(negedge clk);
    for (int i = 0; i < 16; i++) host_send(8'(i), 1'b1);
    if (NCS != 0) host_send(8'h00, 1'b1);
    wait_idle("read done");
    bus_rd(A_STAT, r);  check("read status", r, 32'h4 | CS);
    check("read irq", 32'(irq_cnt - irq0), 32'h1);
    bus_rd(9'h000, r);  check("read word0", r, 32'h0302_0100);
    bus_rd(9'h001, r);  check("read word1", r, 32'h0706_0504);
    bus_rd(9'h003, r);  check("read word3", r, 32'h0F0E_0D0C);

    // Write sector with ACK; buffer write and CMD while busy are both dropped
    bus_wr(9'h000, 32'hDEAD_BEEF);
    for (int i = 1; i < SW; i++) bus_wr(9'(i), 32'h0);
    bus_wr(A_LBA, 32'h1);
    irq0 = irq_cnt;
    tx_q.delete();
    bus_wr(A_CMD, 32'h2);
    wait_txq(7, "write early");
    bus_wr(9'h001, 32'hBAD0_BAD0);
    bus_wr(A_CMD, 32'h1);
    wait_txq(NW, "write frame");
    repeat (2*CLK_DIV) @(negedge clk);
    host_send(8'h06, 1'b1);
    wait_idle("write done");
    bus_rd(A_STAT, r);  check("write status", r, 32'h4 | CS);
    check("write irq", 32'(irq_cnt - irq0), 32'h1);
    repeat (20*CLK_DIV) @(negedge clk);
    exp = '{8'h57, 8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 12; i++) exp.push_back(8'h00);
    if (NCS != 0) exp.push_back(8'h22);
    check_tx("write frame", exp);
    bus_rd(9'h001, r);  check("busy buf write dropped", r, 32'h0);

    // Write sector with NAK
    irq0 = irq_cnt;
    tx_q.delete();
    bus_wr(A_CMD, 32'h2);
    wait_txq(NW, "nak frame");
    repeat (2*CLK_DIV) @(negedge clk);
    host_send(8'h15, 1'b1);
    wait_idle("nak done");
    bus_rd(A_STAT, r);  check("nak status", r, 32'h2 | CS);
    check("nak irq", 32'(irq_cnt - irq0), 32'h1);

    // Read sector, host stalls after 3 bytes
    irq0 = irq_cnt;
    tx_q.delete();
    bus_wr(A_CMD, 32'h1);
    wait_txq(5, "tmo hdr");
    repeat (2*CLK_DIV) @(negedge clk);
    for (int i = 0; i < 3; i++) host_send(8'h11 * 8'(i + 1), 1'b1);
    repeat (TMO/2) @(negedge clk);
    bus_rd(A_STAT, r);  check("tmo still busy", r, 32'h1 | CS);
    wait_idle("tmo done");
    bus_rd(A_STAT, r);  check("tmo status", r, 32'h2 | CS);
    check("tmo irq", 32'(irq_cnt - irq0), 32'h1);

    // Bad stop bit during read
    tx_q.delete();
    bus_wr(A_CMD, 32'h1);
    wait_txq(5, "stop hdr");
    repeat (2*CLK_DIV) @(negedge clk);
    host_send(8'h5A, 1'b0);
    wait_idle("stop done");
    bus_rd(A_STAT, r);  check("bad stop status", r, 32'h2 | CS);

    // Reset in the middle of RX_DATA
    irq0 = irq_cnt;
    tx_q.delete();
    bus_wr(A_LBA, 32'h77);
    bus_wr(A_CMD, 32'h1);
    wait_txq(5, "rst hdr");
    repeat (2*CLK_DIV) @(negedge clk);
    host_send(8'hAA, 1'b1);
    host_send(8'h55, 1'b1);
    RxD = 1'b0;
    repeat (3*CLK_DIV/2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst TxD", {31'h0, TxD}, 32'h1);
    check("rst bus_rdata", bus_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0; RxD = 1'b1;
    bus_rd(A_STAT, r);  check("rst status", r, CS);
    bus_rd(A_LBA, r);   check("rst lba", r, 32'h0);
    repeat (20*CLK_DIV) @(negedge clk);
    check("rst irq", 32'(irq_cnt - irq0), 32'h0);
    check("rst tx count", 32'(tx_q.size()), 32'h5);
    check("tx stop bits", 32'(tx_frm), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/disk_uart_ctrl.md
Name: disk_uart_ctrl

Overview:
- Memory-mapped disk controller; next generation of the UART-backed disk block.
- Holds one sector in an internal word buffer the CPU reads and writes over the memory bus.
- Moves whole sectors to and from a host PC over a UART link on command.
- Generalised in sector size, address width and baud rate; adds command/status registers, write-back with ACK, and a timeout.

Parameters:
- ADDR_W, 9, bus word-address width; bit ADDR_W-1 = 1 selects registers, 0 selects buffer.
- SECTOR_WORDS, 128, 32-bit words per sector; must be a power of 2 and ≤ 2^(ADDR_W-1).
- CLK_DIV, 434, clock cycles per UART bit (8N1).
- TIMEOUT_CYC, 2_000_000, idle cycles allowed between received bytes before error.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- Memread  in  1  bus read strobe.
- Memwrite  in  1  bus write strobe.
- Addrin  in  ADDR_W  word address.
- bus_wdata  in  32  write data.
- bus_rdata  out  32  read data; registered, valid the cycle after Memread.
- RxD  in  1  UART receive; double-flop synchronised internally.
- TxD  out  1  UART transmit; idles high.
- irq  out  1  one-cycle pulse when a command completes or fails.

Behaviour:
- Register map, selected when Addrin[ADDR_W-1] = 1; low bits decode as follows:
  - 0x0 STATUS (RO): bit0 busy, bit1 error, bit2 done.
  - 0x1 LBA (RW, 32-bit).
  - 0x2 CMD (WO): 1 = read sector, 2 = write sector, other values ignored.
  - Undefined register offsets read as 0.
- Buffer access: Addrin[ADDR_W-2:0] mod SECTOR_WORDS indexes the buffer.
  - CPU buffer writes while busy are dropped.
  - CPU buffer reads are always allowed.
- Reset values: bus_rdata = 0, TxD = 1, irq = 0, STATUS = 0, LBA = 0, FSM = IDLE. Buffer contents are undefined.
- Writing CMD while busy is ignored.
- Writing a valid CMD clears done and error, sets busy, and moves FSM IDLE→TX_HDR.
- TX_HDR sends 5 bytes: 0x52 ('R') or 0x57 ('W'), then LBA, least-significant byte first.
- Read command: TX_HDR→RX_DATA.
  - Receive SECTOR_WORDS*4 bytes, little-endian per word, into the buffer starting at word 0.
  - Then go to FIN.
- Write command: TX_HDR→TX_DATA→RX_ACK.
  - TX_DATA sends the buffer as SECTOR_WORDS*4 bytes, little-endian.
  - RX_ACK waits for one byte: 0x06 → FIN; any other byte → FAIL.
- FIN: busy = 0, done = 1, irq pulses for 1 cycle, FSM → IDLE.
- FAIL: busy = 0, error = 1, irq pulses for 1 cycle, FSM → IDLE.
- Timeout: in RX_DATA or RX_ACK, a counter clears on each received byte. Reaching TIMEOUT_CYC → FAIL. Buffer words already written stay written.
- UART RX:
  - Start bit detected on a falling edge, sampled at mid-bit (CLK_DIV/2).
  - A bad stop bit (0) discards the byte and goes to FAIL in RX states.
  - Bytes arriving while in IDLE or TX states are discarded.
- UART TX: back-to-back bytes with no idle gap between stop and next start bit.
- Simultaneous Memwrite to CMD and completion in the same cycle: completion wins; the CMD write is dropped.
- Reset mid-transfer: FSM → IDLE, TxD high on the next cycle, partial byte abandoned.

Optional Feature:
- Macro DISK_CHECKSUM_EN.
- Defined:
  - Read: after data, one extra byte is received, the XOR of all data bytes. A mismatch → FAIL; it is checked before FIN.
  - Write: the controller sends the XOR byte after data, before RX_ACK.
  - STATUS bit3 reads 1 (feature present).
- Not defined: no checksum byte in either direction; STATUS bit3 reads 0.

Test Plan:
- Reset → bus_rdata 0, TxD 1, STATUS reads 0x0 (or 0x8 with DISK_CHECKSUM_EN).
- LBA = 0x00000005, CMD = 1 (CLK_DIV = 8, SECTOR_WORDS = 4):
  - TxD emits 52 05 00 00 00.
  - Host sends bytes 0x00..0x0F.
  - Buffer word 0 reads 0x03020100 and word 3 reads 0x0F0E0D0C.
  - STATUS = 0x4 and irq pulses once.
- CPU writes buffer word 0 = 0xDEADBEEF, others 0; LBA = 1; CMD = 2:
  - TxD emits 57 01 00 00 00 EF BE AD DE followed by 12 zero bytes.
  - Host replies 0x06 → STATUS = 0x4.
- Write command with host reply 0x15 → STATUS = 0x2 and irq pulses.
- Read command, host stops after 3 bytes → after TIMEOUT_CYC (bench: 200) STATUS = 0x2 and FSM is idle.
- CMD = 1 written again while busy → no second header on TxD. Also assert rst mid-RX_DATA → STATUS = 0 and TxD = 1 the next cycle.
